// File: rtl/wb_cmd_master.sv
// Wishbone classic master fed by a command FIFO, returning one response per command,
// with an interrupt-enable shadow snooped from writes to the target control register.
module wb_cmd_master #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CMD_DEPTH  = 4,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned IE_ADDR    = 0,
  parameter int unsigned IE_BIT     = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // command push
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  // response pop
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic                  rsp_we_o,
  output logic                  rsp_err_o,
  // wishbone classic master
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  ack_i,
  // interrupt gating
  input  logic                  irq_i,
  output logic                  irq_o,
  output logic                  irq_viol_o,
  input  logic                  viol_clr_i
);

  localparam int unsigned PTR_W = $clog2(CMD_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t           state;
  cmd_t             mem [CMD_DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [TO_W-1:0]  to_cnt;
  logic [TO_W-1:0]  to_inc;
  logic             push;
  logic             pop;
  logic             ie;

  assign push   = cmd_valid_i && cmd_ready_o;
  assign pop    = (state == IDLE) && (count != '0);
  assign head   = mem[rd_ptr];
  assign to_inc = to_cnt + TO_W'(1);
  assign irq_o  = irq_i & ie;

  always_comb begin
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  // FIFO storage needs no reset: only entries below count are ever read
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= '{we: cmd_we_i, adr: cmd_adr_i, dat: cmd_dat_i};
    end
  end

  // FIFO pointers, occupancy and the registered ready flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cmd_ready_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count_nxt;
      cmd_ready_o <= (count_nxt != CNT_W'(CMD_DEPTH));
    end
  end

  // transfer sequencer with registered bus and response outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
      we_o        <= 1'b0;
      adr_o       <= '0;
      dat_o       <= '0;
      to_cnt      <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_we_o    <= 1'b0;
      rsp_err_o   <= 1'b0;
      ie          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state  <= BUS;
            cyc_o  <= 1'b1;
            stb_o  <= 1'b1;
            we_o   <= head.we;
            adr_o  <= head.adr;
            dat_o  <= head.we ? head.dat : '0;
            to_cnt <= '0;
          end
        end
        BUS: begin
          if (ack_i) begin
            state       <= RESP;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            adr_o       <= '0;
            dat_o       <= '0;
            rsp_valid_o <= 1'b1;
            rsp_we_o    <= we_o;
            rsp_dat_o   <= we_o ? '0 : dat_i;
            rsp_err_o   <= 1'b0;
            if (we_o && (adr_o == ADDR_WIDTH'(IE_ADDR))) begin
              ie <= dat_o[IE_BIT];
            end
          end else begin
            to_cnt <= to_inc;
            // the cycle that brings the wait count to TIMEOUT is the last one on the bus
            if (to_inc == TO_W'(TIMEOUT)) begin
              state       <= RESP;
              cyc_o       <= 1'b0;
              stb_o       <= 1'b0;
              we_o        <= 1'b0;
              adr_o       <= '0;
              dat_o       <= '0;
              rsp_valid_o <= 1'b1;
              rsp_we_o    <= we_o;
              rsp_dat_o   <= '0;
              rsp_err_o   <= 1'b1;
            end
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // sticky violation: a new violation outranks a simultaneous clear
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      irq_viol_o <= 1'b0;
    end else if (irq_i && !ie) begin
      irq_viol_o <= 1'b1;
    end else if (viol_clr_i) begin
      irq_viol_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: transaction-level reference model checked every cycle,
// plus literal expectations for the headline scenarios.
module tb_wb_cmd_master;

  localparam int unsigned AW      = 2;
  localparam int unsigned DW      = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TMO     = 255;
  localparam int unsigned IE_A    = 0;
  localparam int unsigned IE_B    = 6;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [AW-1:0] cmd_adr_i;
  logic [DW-1:0] cmd_dat_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_we_o, rsp_err_o;
  logic [DW-1:0] rsp_dat_o;
  logic          cyc_o, stb_o, we_o, ack_i;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o, dat_i;
  logic          irq_i, irq_o, irq_viol_o, viol_clr_i;

  wb_cmd_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(DEPTH),
    .TIMEOUT(TMO), .IE_ADDR(IE_A), .IE_BIT(IE_B)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_we_o(rsp_we_o), .rsp_err_o(rsp_err_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i),
    .irq_i(irq_i), .irq_o(irq_o), .irq_viol_o(irq_viol_o), .viol_clr_i(viol_clr_i)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // scripted target: ack after ack_wait stalls (negative = never), read data fixed
  int        ack_wait = 0;
  int        wcnt     = 0;
  logic      tgt_ack  = 1'b0;
  logic      stray_ack = 1'b0;
  logic [7:0] rd_val  = 8'h00;
  assign ack_i = tgt_ack | stray_ack;
  assign dat_i = rd_val;

  always @(negedge clk) begin
    if (cyc_o && stb_o) begin
      tgt_ack = (ack_wait >= 0) && (wcnt == ack_wait);
      wcnt++;
    end else begin
      tgt_ack = 1'b0;
      wcnt    = 0;
    end
  end

  // reference model: queue of pending commands and one transaction at a time
  typedef struct { bit we; bit [AW-1:0] adr; bit [DW-1:0] dat; } tcmd_t;
  tcmd_t      mq[$];
  tcmd_t      cur;
  int         ph;      // 0 waiting for work, 1 on the bus, 2 holding a response
  int         wt;
  bit         e_cyc, e_we, e_rv, e_rwe, e_rerr, e_ie, e_viol, e_rdy;
  bit [AW-1:0] e_adr;
  bit [DW-1:0] e_dat, e_rdat;

  task automatic model_end_bus(input bit err);
    e_cyc = 0; e_we = 0; e_adr = '0; e_dat = '0;
    e_rv = 1; e_rwe = cur.we; e_rerr = err;
    e_rdat = (err || cur.we) ? '0 : dat_i;
    ph = 2;
  endtask

  always @(posedge clk or negedge rst_i) begin : model
    bit take;
    if (!rst_i) begin
      mq.delete(); ph = 0; wt = 0;
      e_cyc = 0; e_we = 0; e_adr = '0; e_dat = '0;
      e_rv = 0; e_rdat = '0; e_rwe = 0; e_rerr = 0;
      e_ie = 0; e_viol = 0; e_rdy = 0;
    end else begin
      take = cmd_valid_i && e_rdy;
      if (irq_i && !e_ie) e_viol = 1;
      else if (viol_clr_i) e_viol = 0;
      case (ph)
        0: if (mq.size() > 0) begin
             cur = mq.pop_front();
             ph = 1; wt = 0;
             e_cyc = 1; e_we = cur.we; e_adr = cur.adr;
             e_dat = cur.we ? cur.dat : '0;
           end
        1: if (ack_i) begin
             if (cur.we && cur.adr == AW'(IE_A)) e_ie = cur.dat[IE_B];
             model_end_bus(1'b0);
           end else begin
             wt++;
             if (wt == int'(TMO)) model_end_bus(1'b1);
           end
        default: if (rsp_ready_i) begin e_rv = 0; ph = 0; end
      endcase
      if (take) mq.push_back('{we: cmd_we_i, adr: cmd_adr_i, dat: cmd_dat_i});
      e_rdy = (mq.size() != int'(DEPTH));
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_o", cyc_o, e_cyc);
      chk("stb_o", stb_o, e_cyc);
      chk("we_o", we_o, e_we);
      chk("adr_o", adr_o, e_adr);
      chk("dat_o", dat_o, e_dat);
      chk("cmd_ready_o", cmd_ready_o, e_rdy);
      chk("rsp_valid_o", rsp_valid_o, e_rv);
      chk("irq_o", irq_o, irq_i & e_ie);
      chk("irq_viol_o", irq_viol_o, e_viol);
      if (e_rv) begin
        chk("rsp_dat_o", rsp_dat_o, e_rdat);
        chk("rsp_we_o", rsp_we_o, e_rwe);
        chk("rsp_err_o", rsp_err_o, e_rerr);
      end
    end
  end

  // entered and left just after a rising edge
  task automatic push(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    bit rdy = 0;
    int n = 0;
    cmd_valid_i = 1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat;
    while (!rdy && n < 50) begin
      @(negedge clk); rdy = cmd_ready_o;
      @(posedge clk); #1; n++;
    end
    chk("push_accepted", rdy, 1);
    cmd_valid_i = 0;
  endtask

  // leaves on the falling edge where rsp_valid_o is first seen
  task automatic wait_rsp(input int max, output int cn, output logic [AW-1:0] sa,
                          output logic [DW-1:0] sd);
    bit ok = 0;
    cn = 0; sa = '0; sd = '0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (cyc_o) begin cn++; sa = adr_o; sd = dat_o; end
      if (rsp_valid_o) ok = 1;
    end
    chk("wait_rsp", ok, 1);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  int          cn, nrsp, ncyc;
  logic [AW-1:0] sa;
  logic [DW-1:0] sd;

  initial begin
    rst_i = 0; cmd_valid_i = 0; cmd_we_i = 0; cmd_adr_i = '0; cmd_dat_i = '0;
    rsp_ready_i = 1; irq_i = 0; viol_clr_i = 0;
    @(posedge clk); chk_en = 1;
    @(negedge clk);
    chk("reset_ready", cmd_ready_o, 0);
    chk("reset_cyc", cyc_o, 0);
    chk("reset_rsp_valid", rsp_valid_o, 0);
    step(); rst_i = 1;
    @(negedge clk); chk("ready_before_first_edge", cmd_ready_o, 0);
    step(); @(negedge clk); chk("ready_after_release", cmd_ready_o, 1);
    step();

    // write 0x80 to addr 2 acked after two wait states
    ack_wait = 2;
    push(1, 2'd2, 8'h80);
    wait_rsp(20, cn, sa, sd);
    chk("wr_cyc_len", cn, 3);
    chk("wr_adr", sa, 2);
    chk("wr_dat", sd, 8'h80);
    chk("wr_rsp_we", rsp_we_o, 1);
    chk("wr_rsp_err", rsp_err_o, 0);
    chk("wr_rsp_dat", rsp_dat_o, 0);
    step();

    // read addr 1, target returns 0x5A
    ack_wait = 0; rd_val = 8'h5A;
    push(0, 2'd1, 8'h33);
    wait_rsp(20, cn, sa, sd);
    chk("rd_cyc_len", cn, 1);
    chk("rd_dat_o_zero", sd, 0);
    chk("rd_rsp_dat", rsp_dat_o, 8'h5A);
    chk("rd_rsp_err", rsp_err_o, 0);
    step();

    // fill: four buffered plus one in flight while responses are held back
    rsp_ready_i = 0;
    push(1, 2'd3, 8'h01);
    push(0, 2'd1, 8'h02);
    push(1, 2'd2, 8'h03);
    push(1, 2'd3, 8'h04);
    push(0, 2'd2, 8'h05);
    @(negedge clk); chk("full_ready_low", cmd_ready_o, 0);
    step();
    cmd_valid_i = 1; cmd_we_i = 1; cmd_adr_i = 2'd1; cmd_dat_i = 8'hEE;
    repeat (3) step();
    cmd_valid_i = 0;
    rsp_ready_i = 1; nrsp = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid_o && rsp_ready_i) nrsp++;
    end
    chk("drain_rsp_count", nrsp, 5);
    step();

    // interrupt enable set by write of 0x40 to the control register
    push(1, 2'd0, 8'h40);
    wait_rsp(20, cn, sa, sd); step();
    irq_i = 1; @(negedge clk); chk("irq_enabled", irq_o, 1);
    step(); irq_i = 0; @(negedge clk); chk("viol_clear_when_enabled", irq_viol_o, 0);
    step();
    push(1, 2'd0, 8'h00);
    wait_rsp(20, cn, sa, sd); step();
    irq_i = 1; @(negedge clk); chk("irq_masked", irq_o, 0);
    step(); irq_i = 0; @(negedge clk); chk("viol_set", irq_viol_o, 1);
    repeat (2) step();
    @(negedge clk); chk("viol_sticky", irq_viol_o, 1);
    step(); irq_i = 1; viol_clr_i = 1;
    step(); irq_i = 0; @(negedge clk); chk("viol_set_beats_clear", irq_viol_o, 1);
    step(); viol_clr_i = 0; @(negedge clk); chk("viol_cleared", irq_viol_o, 0);
    step();

    // acks while idle are ignored
    stray_ack = 1; repeat (2) step(); stray_ack = 0;
    @(negedge clk); chk("stray_ack_no_rsp", rsp_valid_o, 0);
    step();

    // timed-out write to the control register leaves the enable alone
    ack_wait = -1;
    push(1, 2'd0, 8'h40);
    wait_rsp(400, cn, sa, sd);
    chk("tmo_cyc_len", cn, 255);
    chk("tmo_rsp_err", rsp_err_o, 1);
    chk("tmo_rsp_dat", rsp_dat_o, 0);
    step();
    irq_i = 1; @(negedge clk); chk("tmo_ie_unchanged", irq_o, 0);
    step(); irq_i = 0; viol_clr_i = 1; step(); viol_clr_i = 0;
    ack_wait = 0; rd_val = 8'hC3;
    push(0, 2'd3, 8'h00);
    wait_rsp(20, cn, sa, sd);
    chk("after_tmo_rsp_dat", rsp_dat_o, 8'hC3);
    chk("after_tmo_rsp_err", rsp_err_o, 0);
    step();

    // reset during a bus cycle with two commands still queued
    ack_wait = -1;
    push(1, 2'd1, 8'h11);
    push(1, 2'd2, 8'h22);
    push(0, 2'd3, 8'h33);
    repeat (3) step();
    rst_i = 0; #1;
    chk("rst_cyc_immediate", cyc_o, 0);
    chk("rst_stb_immediate", stb_o, 0);
    chk("rst_ready_low", cmd_ready_o, 0);
    step(); rst_i = 1; ack_wait = 0;
    nrsp = 0; ncyc = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid_o) nrsp++;
      if (cyc_o) ncyc++;
    end
    chk("post_rst_no_rsp", nrsp, 0);
    chk("post_rst_fifo_empty", ncyc, 0);
    chk("post_rst_ready", cmd_ready_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

endmodule
